// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit_pkg
// Purpose  : Shared definitions for the ONC-16 program counter: datapath
//            widths, target-source selector encodings and the reset address.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pc_unit_pkg;

    localparam int DATA_W       = 16;
    localparam int PC_IMR_SEL_W = 1;
    localparam int PC_BR_SEL_W  = 1;

    // Target-source selector: zero picks PC-relative, any nonzero picks rs.
    localparam int PC_SEL_IMM = 0;
    localparam int PC_SEL_REG = 1;

    localparam logic [DATA_W-1:0] PC_RESET_ADDR = 16'h0000;

endpackage : pc_unit_pkg
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_sel
// Purpose  : Combinational next-address selection for the program counter.
//            bre = 0            -> pc + INC_STEP (sequential fetch)
//            bre = 1, sel == 0  -> pc + imm      (relative to current pc)
//            bre = 1, sel != 0  -> rs            (register absolute)
//            All sums wrap modulo 2^DATA_W.
// Ports    : pc      in  DATA_W        current PC
//            imm     in  DATA_W        signed branch offset
//            rs      in  DATA_W        register branch target
//            imr_sel in  PC_IMR_SEL_W  target-source selector
//            bre     in  1             branch enable
//            next_pc out DATA_W        address to load on the next edge
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_sel
    import pc_unit_pkg::*;
#(
    parameter int DATA_W       = pc_unit_pkg::DATA_W,
    parameter int PC_IMR_SEL_W = pc_unit_pkg::PC_IMR_SEL_W,
    parameter int INC_STEP     = 1
) (
    input  logic [DATA_W-1:0]       pc,
    input  logic [DATA_W-1:0]       imm,
    input  logic [DATA_W-1:0]       rs,
    input  logic [PC_IMR_SEL_W-1:0] imr_sel,
    input  logic                    bre,
    output logic [DATA_W-1:0]       next_pc
);

    localparam logic [DATA_W-1:0]       c_inc     = DATA_W'(INC_STEP);
    localparam logic [PC_IMR_SEL_W-1:0] c_sel_imm = PC_IMR_SEL_W'(PC_SEL_IMM);

    always_comb begin
        next_pc = pc + c_inc;
        // bre is tested first so an unknown selector cannot leak into the
        // sequential path.
        if (bre) begin
            if (imr_sel == c_sel_imm) begin
                // Two's-complement add of the raw offset gives the signed,
                // wrapping result directly.
                next_pc = pc + imm;
            end else begin
                next_pc = rs;
            end
        end
    end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : 16-bit program counter for the ONC-16 core. Advances once per
//            clock, or loads a PC-relative / register-absolute branch target
//            when bre is set. Target appears on out one edge after bre is
//            sampled.
// Ports    : clock   in  1             system clock, rising-edge
//            n_rst   in  1             asynchronous reset, active-low
//            imm     in  DATA_W        signed branch offset
//            rs      in  DATA_W        register branch target
//            imr_sel in  PC_IMR_SEL_W  0 = relative, nonzero = register
//            bre     in  1             branch enable
//            hold    in  1             (PC_HOLD_EN only) freeze the PC
//            out     out DATA_W        current PC (registered)
// Options  : define PC_HOLD_EN to add the hold input.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                DATA_W       = pc_unit_pkg::DATA_W,
    parameter int                PC_IMR_SEL_W = pc_unit_pkg::PC_IMR_SEL_W,
    parameter logic [DATA_W-1:0] RESET_ADDR   = pc_unit_pkg::PC_RESET_ADDR,
    parameter int                INC_STEP     = 1
) (
    input  logic                    clock,
    input  logic                    n_rst,
    input  logic [DATA_W-1:0]       imm,
    input  logic [DATA_W-1:0]       rs,
    input  logic [PC_IMR_SEL_W-1:0] imr_sel,
    input  logic                    bre,
`ifdef PC_HOLD_EN
    input  logic                    hold,
`endif
    output logic [DATA_W-1:0]       out
);

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] w_next_pc;
    logic              w_load;

    pc_next_sel #(
        .DATA_W       (DATA_W),
        .PC_IMR_SEL_W (PC_IMR_SEL_W),
        .INC_STEP     (INC_STEP)
    ) u_next_sel (
        .pc      (r_pc),
        .imm     (imm),
        .rs      (rs),
        .imr_sel (imr_sel),
        .bre     (bre),
        .next_pc (w_next_pc)
    );

`ifdef PC_HOLD_EN
    // Hold overrides both increment and branch.
    assign w_load = ~hold;
`else
    assign w_load = 1'b1;
`endif

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_pc <= RESET_ADDR;
        end else if (w_load) begin
            r_pc <= w_next_pc;
        end
    end

    assign out = r_pc;

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Directed self-checking bench for pc_unit. Inputs change and
//            outputs are sampled on the falling clock edge.
// Options  : define PC_HOLD_EN to also exercise the hold input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    logic        clock;
    logic        n_rst;
    logic [15:0] imm;
    logic [15:0] rs;
    logic [0:0]  imr_sel;
    logic        bre;
`ifdef PC_HOLD_EN
    logic        hold;
`endif
    logic [15:0] out;

    int checks   = 0;
    int failures = 0;

    pc_unit dut (
        .clock   (clock),
        .n_rst   (n_rst),
        .imm     (imm),
        .rs      (rs),
        .imr_sel (imr_sel),
        .bre     (bre),
`ifdef PC_HOLD_EN
        .hold    (hold),
`endif
        .out     (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: out=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    // One rising edge, then settle on the following falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        n_rst   = 1'b0;
        imm     = 16'h0000;
        rs      = 16'h0000;
        imr_sel = 1'b0;
        bre     = 1'b0;
`ifdef PC_HOLD_EN
        hold    = 1'b0;
`endif
        #1;
        check("reset_t0", out, 16'h0000);
        #1;
        n_rst = 1'b1;

        // Sequential count from reset: first edge at 5 ns.
        @(negedge clock);
        check("count_1", out, 16'h0001);
        step(); check("count_2", out, 16'h0002);
        step(); check("count_3", out, 16'h0003);

        // Selector and rs ignored while bre = 0.
        imr_sel = 1'b1; rs = 16'h1234;
        step(); check("sel_ignored_4", out, 16'h0004);
        step(); check("sel_ignored_5", out, 16'h0005);
        imr_sel = 1'b0;

        // Relative forward from 0x0005.
        imm = 16'h0080; bre = 1'b1;
        step(); check("rel_fwd", out, 16'h0085);
        bre = 1'b0;
        step(); check("rel_fwd_inc1", out, 16'h0086);
        step(); check("rel_fwd_inc2", out, 16'h0087);

        // Relative backward from 0x0087 by 16.
        imm = 16'hFFF0; bre = 1'b1;
        step(); check("rel_back", out, 16'h0077);
        bre = 1'b0;
        step(); check("rel_back_inc", out, 16'h0078);

        // Register absolute.
        rs = 16'h8000; imr_sel = 1'b1; bre = 1'b1;
        step(); check("reg_abs", out, 16'h8000);
        bre = 1'b0;
        step(); check("reg_abs_inc", out, 16'h8001);

        rs = 16'hFFFF; bre = 1'b1;
        step(); check("reg_ffff", out, 16'hFFFF);
        bre = 1'b0;
        step(); check("wrap_0000", out, 16'h0000);
        step(); check("wrap_0001", out, 16'h0001);

        // Unknown selector with bre = 0 must not disturb the count.
        imr_sel = 1'bx;
        step(); check("sel_x_inc", out, 16'h0002);
        imr_sel = 1'b1;

        // Async reset between edges, with a branch request pending.
        rs = 16'h4321; bre = 1'b1;
        #2 n_rst = 1'b0;
        #1 check("async_rst", out, 16'h0000);
        @(negedge clock);
        check("rst_over_branch", out, 16'h0000);
        bre = 1'b0; imr_sel = 1'b0;
        #2 n_rst = 1'b1;
        @(negedge clock);
        check("restart_1", out, 16'h0001);
        step(); check("restart_2", out, 16'h0002);
        step(); step(); step();
        check("restart_5", out, 16'h0005);

        // Negative offset wrapping below zero.
        imm = 16'hFFF0; bre = 1'b1;
        step(); check("rel_wrap_neg", out, 16'hFFF5);
        bre = 1'b0;
        step(); check("rel_wrap_inc", out, 16'hFFF6);

`ifdef PC_HOLD_EN
        rs = 16'h0010; imr_sel = 1'b1; bre = 1'b1;
        step(); check("hold_setup", out, 16'h0010);
        hold = 1'b1; rs = 16'h5555;
        step(); check("hold_1", out, 16'h0010);
        step(); check("hold_2", out, 16'h0010);
        step(); check("hold_3", out, 16'h0010);
        hold = 1'b0; bre = 1'b0;
        step(); check("hold_release", out, 16'h0011);
        step(); check("hold_release2", out, 16'h0012);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pc_unit
`default_nettype wire
